pc_stack_unit: RTL and testbench

PC_STACK_UNIT -- requirements
Module: pc_stack_unit

---
 rtl/pcu_pkg.sv | 16 +
 rtl/pcu_ras.sv | 86 ++++++++
 rtl/pc_stack_unit.sv | 89 ++++++++
 tb/tb_pc_stack_unit.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/pcu_pkg.sv
// Shared definitions for the PC/return-address-stack unit: PC source encoding
// and default widths.
package pcu_pkg;

  localparam int unsigned PCU_ADDR_W    = 16;
  localparam int unsigned PCU_RAS_DEPTH = 4;

  // PCMUX source select encoding
  typedef enum logic [1:0] {
    PC_SRC_BUS  = 2'b00,
    PC_SRC_ADDR = 2'b01,
    PC_SRC_INC  = 2'b10,
    PC_SRC_RET  = 2'b11
  } pc_src_e;

endpackage

// File: rtl/pcu_ras.sv
// Return-address stack. A push and a pop in the same cycle on a non-empty stack
// overwrite the top entry in place. Overflow and underflow set a sticky error.
// Entry storage is not cleared by reset; only the depth pointer is.
module pcu_ras
  import pcu_pkg::*;
#(
  parameter int unsigned ADDR_W    = PCU_ADDR_W,
  parameter int unsigned RAS_DEPTH = PCU_RAS_DEPTH
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             push,
  input  logic                             pop,
  input  logic [ADDR_W-1:0]                push_data,
  output logic [ADDR_W-1:0]                top,
  output logic [$clog2(RAS_DEPTH+1)-1:0]   depth,
  output logic                             full,
  output logic                             empty,
  output logic                             err
);

  localparam int unsigned DEPTH_W = $clog2(RAS_DEPTH + 1);
  localparam int unsigned IDX_W   = $clog2(RAS_DEPTH);

  logic [ADDR_W-1:0]  mem [RAS_DEPTH];
  logic [DEPTH_W-1:0] depth_nxt;
  logic               err_nxt;
  logic               wr_en;
  logic [IDX_W-1:0]   wr_idx;
  logic [IDX_W-1:0]   top_idx;

  assign top_idx = IDX_W'(depth - DEPTH_W'(1));
  assign top     = empty ? '0 : mem[top_idx];

  // Next depth, error and write slot from the push/pop request
  always_comb begin
    depth_nxt = depth;
    err_nxt   = err;
    wr_en     = 1'b0;
    wr_idx    = '0;
    if (pop && !empty) begin
      if (push) begin
        wr_en  = 1'b1;
        wr_idx = top_idx;
      end else begin
        depth_nxt = depth - DEPTH_W'(1);
      end
    end else begin
      if (pop) begin
        err_nxt = 1'b1;
      end
      if (push) begin
        if (full) begin
          err_nxt = 1'b1;
        end else begin
          wr_en     = 1'b1;
          wr_idx    = IDX_W'(depth);
          depth_nxt = depth + DEPTH_W'(1);
        end
      end
    end
  end

  // Depth pointer, occupancy flags and sticky error
  always_ff @(posedge clk) begin
    if (reset) begin
      depth <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
      err   <= 1'b0;
    end else begin
      depth <= depth_nxt;
      full  <= (depth_nxt == DEPTH_W'(RAS_DEPTH));
      empty <= (depth_nxt == '0);
      err   <= err_nxt;
    end
  end

  // Entry storage, written only at the selected slot
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= push_data;
    end
  end

endmodule

// File: rtl/pc_stack_unit.sv
// Program counter with selectable load source and an optional return-address
// stack. Define PCU_RAS_EN to build the stack; without it PCMUX=11 holds the
// PC, Call is ignored and the stack flags are tied to their empty values.
module pc_stack_unit
  import pcu_pkg::*;
#(
  parameter int unsigned       ADDR_W    = PCU_ADDR_W,
  parameter int unsigned       RAS_DEPTH = PCU_RAS_DEPTH,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
  input  logic                             Clk,
  input  logic                             Reset_ah,
  input  logic                             LD_PC,
  input  logic [1:0]                       PCMUX,
  input  logic [ADDR_W-1:0]                Bus_Data,
  input  logic [ADDR_W-1:0]                Addr_out,
  input  logic                             Call,
  output logic [ADDR_W-1:0]                PC_out,
  output logic                             Ras_empty,
  output logic                             Ras_full,
  output logic [$clog2(RAS_DEPTH+1)-1:0]   Ras_depth,
  output logic                             Ras_err
);

  logic [ADDR_W-1:0] pc_inc_c;
  logic [ADDR_W-1:0] ret_pc_c;
  logic [ADDR_W-1:0] pc_nxt_c;

  assign pc_inc_c = PC_out + ADDR_W'(1);

`ifdef PCU_RAS_EN
  logic              ras_push_c;
  logic              ras_pop_c;
  logic [ADDR_W-1:0] ras_top;

  assign ras_push_c = LD_PC & Call;
  assign ras_pop_c  = LD_PC & (pc_src_e'(PCMUX) == PC_SRC_RET);

  pcu_ras #(
    .ADDR_W    (ADDR_W),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (Clk),
    .reset     (Reset_ah),
    .push      (ras_push_c),
    .pop       (ras_pop_c),
    .push_data (pc_inc_c),
    .top       (ras_top),
    .depth     (Ras_depth),
    .full      (Ras_full),
    .empty     (Ras_empty),
    .err       (Ras_err)
  );

  // Return on an empty stack falls through to the next sequential address
  assign ret_pc_c = Ras_empty ? pc_inc_c : ras_top;
`else
  logic unused_call;

  assign unused_call = Call;
  assign ret_pc_c    = PC_out;
  assign Ras_empty   = 1'b1;
  assign Ras_full    = 1'b0;
  assign Ras_depth   = '0;
  assign Ras_err     = 1'b0;
`endif

  // Next PC source selection
  always_comb begin
    pc_nxt_c = pc_inc_c;
    case (pc_src_e'(PCMUX))
      PC_SRC_BUS:  pc_nxt_c = Bus_Data;
      PC_SRC_ADDR: pc_nxt_c = Addr_out;
      PC_SRC_INC:  pc_nxt_c = pc_inc_c;
      PC_SRC_RET:  pc_nxt_c = ret_pc_c;
      default:     pc_nxt_c = pc_inc_c;
    endcase
  end

  // PC register
  always_ff @(posedge Clk) begin
    if (Reset_ah) begin
      PC_out <= RESET_PC;
    end else if (LD_PC) begin
      PC_out <= pc_nxt_c;
    end
  end

endmodule

// File: tb/tb_pc_stack_unit.sv
// Bench for pc_stack_unit: directed scenarios followed by random traffic, all
// checked each cycle against a queue-based reference model. Follows the
// PCU_RAS_EN build setting of the design.
module tb_pc_stack_unit;
  import pcu_pkg::*;

  localparam int unsigned AW    = 16;
  localparam int unsigned DEPTH = 4;
`ifdef PCU_RAS_EN
  localparam bit RAS_ON = 1'b1;
`else
  localparam bit RAS_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_ah;
  logic          ld_pc;
  logic [1:0]    pcmux;
  logic [AW-1:0] bus_data;
  logic [AW-1:0] addr_out;
  logic          call;
  logic [AW-1:0] pc_out;
  logic          ras_empty;
  logic          ras_full;
  logic [2:0]    ras_depth;
  logic          ras_err;

  int passes = 0;
  int total  = 0;
  string phase = "init";

  // reference model state
  logic [AW-1:0] m_pc;
  logic [AW-1:0] m_stack [$];
  bit            m_err;

  pc_stack_unit #(
    .ADDR_W    (AW),
    .RAS_DEPTH (DEPTH),
    .RESET_PC  (16'h0000)
  ) dut (
    .Clk       (clk),
    .Reset_ah  (reset_ah),
    .LD_PC     (ld_pc),
    .PCMUX     (pcmux),
    .Bus_Data  (bus_data),
    .Addr_out  (addr_out),
    .Call      (call),
    .PC_out    (pc_out),
    .Ras_empty (ras_empty),
    .Ras_full  (ras_full),
    .Ras_depth (ras_depth),
    .Ras_err   (ras_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s/%s observed=%0h expected=%0h", phase, tag, obs, exp);
  endtask

  task automatic model_reset();
    m_pc  = 16'h0000;
    m_stack.delete();
    m_err = 1'b0;
  endtask

  task automatic model_step(input logic ld, input logic [1:0] mux,
                            input logic [AW-1:0] bus, input logic [AW-1:0] addr,
                            input logic cl);
    logic [AW-1:0] inc;
    logic [AW-1:0] npc;
    bit            popped;
    inc    = m_pc + 16'd1;
    npc    = m_pc;
    popped = 1'b0;
    if (ld) begin
      case (mux)
        2'b00: npc = bus;
        2'b01: npc = addr;
        2'b10: npc = inc;
        default: begin
          if (!RAS_ON) npc = m_pc;
          else if (m_stack.size() > 0) begin
            npc = m_stack[$];
            void'(m_stack.pop_back());
            popped = 1'b1;
          end else begin
            npc   = inc;
            m_err = 1'b1;
          end
        end
      endcase
      if (RAS_ON && cl) begin
        if (m_stack.size() < DEPTH) m_stack.push_back(inc);
        else if (!popped) m_err = 1'b1;
      end
      m_pc = npc;
    end
  endtask

  task automatic check_all();
    check("pc",    32'(pc_out),    32'(m_pc));
    check("depth", 32'(ras_depth), 32'(m_stack.size()));
    check("empty", 32'(ras_empty), 32'(m_stack.size() == 0));
    check("full",  32'(ras_full),  32'(m_stack.size() == DEPTH));
    check("err",   32'(ras_err),   32'(m_err));
  endtask

  task automatic cycle(input logic rst, input logic ld, input logic [1:0] mux,
                       input logic [AW-1:0] bus, input logic [AW-1:0] addr,
                       input logic cl);
    @(negedge clk);
    reset_ah = rst;
    ld_pc    = ld;
    pcmux    = mux;
    bus_data = bus;
    addr_out = addr;
    call     = cl;
    @(posedge clk);
    if (rst) model_reset();
    else model_step(ld, mux, bus, addr, cl);
    #1 check_all();
  endtask

  task automatic load_pc(input logic [AW-1:0] v);
    cycle(1'b0, 1'b1, 2'b00, v, 16'h0000, 1'b0);
  endtask

  initial begin
    reset_ah = 1'b1;
    ld_pc    = 1'b0;
    pcmux    = 2'b00;
    bus_data = '0;
    addr_out = '0;
    call     = 1'b0;
    model_reset();

    phase = "reset";
    cycle(1'b1, 1'b1, 2'b10, 16'hAAAA, 16'h5555, 1'b1);

    phase = "inc";
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 2'b10, 16'h0, 16'h0, 1'b0);
    phase = "hold";
    cycle(1'b0, 1'b0, 2'b11, 16'h1234, 16'h4321, 1'b1);
    cycle(1'b0, 1'b0, 2'b00, 16'h1234, 16'h4321, 1'b0);

    phase = "call_ret";
    load_pc(16'h0010);
    cycle(1'b0, 1'b1, 2'b01, 16'h0, 16'h0200, 1'b1);
    cycle(1'b0, 1'b1, 2'b11, 16'h0, 16'h0, 1'b0);

    phase = "overflow";
    for (int i = 0; i < 5; i++) begin
      load_pc(16'h0100 + 16'(i));
      cycle(1'b0, 1'b1, 2'b01, 16'h0, 16'h0800, 1'b1);
    end
    phase = "unwind";
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 2'b11, 16'h0, 16'h0, 1'b0);

    phase = "underflow";
    cycle(1'b1, 1'b0, 2'b00, 16'h0, 16'h0, 1'b0);
    load_pc(16'h0050);
    cycle(1'b0, 1'b1, 2'b11, 16'h0, 16'h0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 2'b10, 16'h0, 16'h0, 1'b0);
    phase = "err_clear";
    cycle(1'b1, 1'b0, 2'b00, 16'h0, 16'h0, 1'b0);

    phase = "wrap";
    load_pc(16'hFFFF);
    cycle(1'b0, 1'b1, 2'b10, 16'h0, 16'h0, 1'b0);
    load_pc(16'hFFFF);
    cycle(1'b0, 1'b1, 2'b01, 16'h0, 16'h0300, 1'b1);
    cycle(1'b0, 1'b1, 2'b11, 16'h0, 16'h0, 1'b0);

    phase = "call_and_ret";
    load_pc(16'h1233);
    cycle(1'b0, 1'b1, 2'b00, 16'h5000, 16'h0, 1'b1);
    cycle(1'b0, 1'b1, 2'b11, 16'h0, 16'h0, 1'b1);
    cycle(1'b0, 1'b1, 2'b11, 16'h0, 16'h0, 1'b0);

    phase = "empty_ret_call";
    cycle(1'b1, 1'b0, 2'b00, 16'h0, 16'h0, 1'b0);
    load_pc(16'h0700);
    cycle(1'b0, 1'b1, 2'b11, 16'h0, 16'h0, 1'b1);
    cycle(1'b0, 1'b1, 2'b11, 16'h0, 16'h0, 1'b0);

    phase = "random";
    for (int n = 0; n < 800; n++) begin
      logic          r_rst;
      logic          r_ld;
      logic [1:0]    r_mux;
      logic          r_call;
      logic [AW-1:0] r_bus;
      logic [AW-1:0] r_addr;
      r_rst  = ($urandom_range(0, 63) == 0);
      r_ld   = ($urandom_range(0, 3) != 0);
      r_mux  = 2'($urandom_range(0, 3));
      r_call = ($urandom_range(0, 2) == 0);
      r_bus  = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
      r_addr = 16'($urandom);
      cycle(r_rst, r_ld, r_mux, r_bus, r_addr, r_call);
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
